// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered snapshot capture of saturated ADC samples with oldest-first valid/ready readout
// Ports: clk_adc/rst_n clock and async active-low reset; adc_samples/sample_valid sample stream;
// overflow_detect sticky-overflow source; arm/force_trig control pulses; trig_level/pre_trig trigger setup;
// rd_data/rd_valid/rd_ready readout stream; state FSM encoding; readout_done end-of-window pulse; ovr_seen sticky flag.
module adc_capture_buffer #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_adc,
  input  logic                  rst_n,
  input  logic signed [31:0]    adc_samples,
  input  logic                  sample_valid,
  input  logic                  overflow_detect,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic signed [15:0]    trig_level,
  input  logic [DEPTH_LOG2-1:0] pre_trig,
  output logic signed [15:0]    rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [2:0]            state,
  output logic                  readout_done,
  output logic                  ovr_seen
);
  localparam int W = DEPTH_LOG2;
  localparam int DEPTH = 1 << W;
  typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, ARMED = 3'd2, POST = 3'd3, READ = 3'd4} st_t;
  st_t st;
  logic signed [15:0] mem [DEPTH];
  logic signed [15:0] sat, prev, ram_q, skid_data;
  logic [W-1:0] wp, cnt, nxt_cnt, pre_lat, trig_addr, ra, dcnt;
  logic [W:0] iss;
  logic prev_valid, force_l, q_vld, skid_vld, we, trig, xfer, issue, capturing;
  logic [1:0] occ;
  assign state = st;
  always_comb begin
    sat = adc_samples > 32767 ? 16'sh7fff : adc_samples < -32768 ? -16'sh8000 : adc_samples[15:0];
    capturing = st == FILL || st == ARMED || st == POST;
    we = sample_valid && !arm && capturing;
    nxt_cnt = cnt + 1'b1;
    trig = (prev_valid && prev < trig_level && sat >= trig_level) || force_l;
    xfer = rd_valid && rd_ready;
    // words held or in flight after this cycle's transfer; at most two fit (output + skid)
    occ = 2'(rd_valid) + 2'(skid_vld) + 2'(q_vld) - 2'(xfer);
    issue = st == READ && !arm && !iss[W] && occ < 2'd2;
  end
  always_ff @(posedge clk_adc) begin
    if (we) mem[wp] <= sat;
    if (issue) ram_q <= mem[ra];
  end
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      wp <= '0;
      cnt <= '0;
      pre_lat <= '0;
      prev <= '0;
      prev_valid <= 1'b0;
      force_l <= 1'b0;
      trig_addr <= '0;
      ra <= '0;
      iss <= '0;
      dcnt <= '0;
      q_vld <= 1'b0;
      skid_vld <= 1'b0;
      skid_data <= '0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      readout_done <= 1'b0;
      ovr_seen <= 1'b0;
    end else begin
      readout_done <= 1'b0;
      if (arm) begin
        st <= pre_trig == '0 ? ARMED : FILL;
        pre_lat <= pre_trig;
        wp <= '0;
        cnt <= '0;
        prev_valid <= 1'b0;
        force_l <= 1'b0;
        ovr_seen <= 1'b0;
        iss <= '0;
        dcnt <= '0;
        q_vld <= 1'b0;
        skid_vld <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        if (capturing && overflow_detect) ovr_seen <= 1'b1;
        if ((st == FILL || st == ARMED) && force_trig) force_l <= 1'b1;
        if (we) wp <= wp + 1'b1;
        // prev spans FILL->ARMED so a crossing straddling the boundary still triggers
        if (we && st != POST) begin
          prev <= sat;
          prev_valid <= 1'b1;
        end
        if (we && st == FILL) begin
          cnt <= nxt_cnt;
          if (nxt_cnt == pre_lat) begin
            st <= ARMED;
            cnt <= '0;
          end
        end
        if (we && st == ARMED && trig) begin
          force_l <= 1'b0;
          trig_addr <= wp;
          cnt <= '0;
          ra <= wp - pre_lat;
          st <= pre_lat == '1 ? READ : POST;
        end
        // POST length is DEPTH-1-pre_lat, which is ~pre_lat in W bits
        if (we && st == POST) begin
          cnt <= nxt_cnt;
          if (nxt_cnt == ~pre_lat) begin
            st <= READ;
            ra <= trig_addr - pre_lat;
          end
        end
        q_vld <= issue;
        if (issue) begin
          ra <= ra + 1'b1;
          iss <= iss + 1'b1;
        end
        if (!rd_valid || rd_ready) begin
          rd_valid <= skid_vld || q_vld;
          if (skid_vld) rd_data <= skid_data;
          else if (q_vld) rd_data <= ram_q;
          skid_vld <= skid_vld && q_vld;
          if (skid_vld && q_vld) skid_data <= ram_q;
        end else if (q_vld) begin
          skid_vld <= 1'b1;
          skid_data <= ram_q;
        end
        if (xfer) begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == '1) begin
            readout_done <= 1'b1;
            st <= IDLE;
          end
        end
      end
    end
  end
endmodule
